uart_axis: RTL and testbench

//  Full-duplex 8N1 UART with AXI-Stream byte interfaces and runtime baud prescale.

---
 rtl/uart_axis.sv | 191 +++++++++++++++++++
 tb/tb_uart_axis.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_axis.sv
// uart_axis: full-duplex 8N1 UART with AXI-Stream byte interfaces.
//   Frame = start(0) + DATA_WIDTH data bits LSB-first + stop(1), no parity.
//   Bit time T = prescale*8 clocks (prescale 0 behaves as 1), captured per frame.
// Ports:
//   clk, rst                      clock, async active-high reset
//   input_axis_tdata/tvalid/tready   TX byte stream (sink side)
//   output_axis_tdata/tvalid/tready  RX byte stream (source side)
//   rxd / txd                     serial in / out, idle high
//   tx_busy / rx_busy             frame in progress
//   rx_overrun_error              1-clk pulse: new byte replaced an unread one
//   rx_frame_error                1-clk pulse: stop bit sampled low
//   prescale                      clocks per 1/8 bit
module uart_axis #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  input  logic                  rxd,
  output logic                  txd,
  output logic                  tx_busy,
  output logic                  rx_busy,
  output logic                  rx_overrun_error,
  output logic                  rx_frame_error,
  input  logic [15:0]           prescale
);

  localparam int BW = $clog2(DATA_WIDTH + 2);

  localparam logic       TX_IDLE  = 1'b0;
  localparam logic       TX_RUN   = 1'b1;
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Bit and half-bit lengths, minus one, for loading down-counters.
  logic [15:0] pre_eff;
  logic [18:0] bit_len_m1;
  logic [18:0] half_len_m1;

  assign pre_eff     = (prescale == 16'd0) ? 16'd1 : prescale;
  assign bit_len_m1  = {pre_eff, 3'b000} - 19'd1;
  assign half_len_m1 = {1'b0, pre_eff, 2'b00} - 19'd1;

  // ---------------- TX ----------------
  logic                tx_state;
  logic [18:0]         tx_cnt;
  logic [18:0]         tx_len;
  logic [BW-1:0]       tx_bits;
  logic [DATA_WIDTH:0] tx_sh;    // data bits with the stop bit on top

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state          <= TX_IDLE;
      txd               <= 1'b1;
      input_axis_tready <= 1'b0;
      tx_busy           <= 1'b0;
      tx_cnt            <= '0;
      tx_len            <= '0;
      tx_bits           <= '0;
      tx_sh             <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (input_axis_tready && input_axis_tvalid) begin
            tx_sh             <= {1'b1, input_axis_tdata};
            txd               <= 1'b0;
            input_axis_tready <= 1'b0;
            tx_busy           <= 1'b1;
            tx_cnt            <= bit_len_m1;
            tx_len            <= bit_len_m1;
            tx_bits           <= BW'(DATA_WIDTH + 1);
            tx_state          <= TX_RUN;
          end else begin
            input_axis_tready <= 1'b1;
          end
        end
        default: begin
          if (tx_cnt != 19'd0) begin
            tx_cnt <= tx_cnt - 19'd1;
          end else if (tx_bits != '0) begin
            txd     <= tx_sh[0];
            tx_sh   <= tx_sh >> 1;
            tx_bits <= tx_bits - BW'(1);
            tx_cnt  <= tx_len;
          end else begin
            // Stop bit has had its full T; ready again so the next start
            // bit can follow after a single idle clock.
            tx_busy           <= 1'b0;
            input_axis_tready <= 1'b1;
            tx_state          <= TX_IDLE;
          end
        end
      endcase
    end
  end

  // ---------------- RX ----------------
  logic [1:0] rx_sync;
  logic       rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_sync <= 2'b11;
    else     rx_sync <= {rx_sync[0], rxd};
  end

  assign rxs = rx_sync[1];

  logic [1:0]            rx_state;
  logic [18:0]           rx_cnt;
  logic [18:0]           rx_len;
  logic [BW-1:0]         rx_bits;
  logic [DATA_WIDTH-1:0] rx_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state           <= RX_IDLE;
      rx_busy            <= 1'b0;
      rx_cnt             <= '0;
      rx_len             <= '0;
      rx_bits            <= '0;
      rx_sh              <= '0;
      output_axis_tdata  <= '0;
      output_axis_tvalid <= 1'b0;
      rx_overrun_error   <= 1'b0;
      rx_frame_error     <= 1'b0;
    end else begin
      rx_overrun_error <= 1'b0;
      rx_frame_error   <= 1'b0;
      if (output_axis_tvalid && output_axis_tready) output_axis_tvalid <= 1'b0;

      case (rx_state)
        RX_IDLE: begin
          if (!rxs) begin
            rx_busy  <= 1'b1;
            rx_cnt   <= half_len_m1;
            rx_len   <= bit_len_m1;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt != 19'd0) begin
            rx_cnt <= rx_cnt - 19'd1;
          end else if (rxs) begin
            // Glitch, not a start bit.
            rx_busy  <= 1'b0;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt   <= rx_len;
            rx_bits  <= BW'(DATA_WIDTH);
            rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt != 19'd0) begin
            rx_cnt <= rx_cnt - 19'd1;
          end else begin
            rx_sh   <= {rxs, rx_sh[DATA_WIDTH-1:1]};
            rx_cnt  <= rx_len;
            rx_bits <= rx_bits - BW'(1);
            if (rx_bits == BW'(1)) rx_state <= RX_STOP;
          end
        end
        default: begin
          if (rx_cnt != 19'd0) begin
            rx_cnt <= rx_cnt - 19'd1;
          end else begin
            rx_busy  <= 1'b0;
            rx_state <= RX_IDLE;
            if (rxs) begin
              // Delivery overrides the handshake clear above; a byte taken
              // on this same edge is not an overrun.
              output_axis_tdata  <= rx_sh;
              output_axis_tvalid <= 1'b1;
              rx_overrun_error   <= output_axis_tvalid && !output_axis_tready;
            end else begin
              rx_frame_error <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_axis.sv
// Testbench for uart_axis: table-driven TX/RX frames plus hand-written
// sequences for reset, false start, overrun, accept/deliver collision and
// loopback streaming.
module tb_uart_axis;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b1;
  logic        rxd_drv = 1'b1;
  logic        loopback = 1'b0;
  logic        rxd;
  logic        txd;
  logic        tx_busy;
  logic        rx_busy;
  logic        ovr;
  logic        fe;
  logic [15:0] prescale = 16'd27;

  assign rxd = loopback ? txd : rxd_drv;

  uart_axis #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .input_axis_tdata(tx_data), .input_axis_tvalid(tx_valid), .input_axis_tready(tx_ready),
    .output_axis_tdata(rx_data), .output_axis_tvalid(rx_valid), .output_axis_tready(rx_ready),
    .rxd(rxd), .txd(txd), .tx_busy(tx_busy), .rx_busy(rx_busy),
    .rx_overrun_error(ovr), .rx_frame_error(fe), .prescale(prescale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples just after the falling edge.
  int         vcyc = 0, ovr_n = 0, fe_n = 0, long_n = 0, rx_n = 0;
  logic       ovr_q = 1'b0, fe_q = 1'b0;
  logic [7:0] rx_log [64];

  always @(negedge clk) begin
    #1;
    if (rx_valid) vcyc <= vcyc + 1;
    if (rx_valid && rx_ready) begin
      rx_log[rx_n % 64] <= rx_data;
      rx_n <= rx_n + 1;
    end
    if (ovr) ovr_n <= ovr_n + 1;
    if (fe)  fe_n  <= fe_n + 1;
    if ((ovr && ovr_q) || (fe && fe_q)) long_n <= long_n + 1;
    ovr_q <= ovr;
    fe_q  <= fe;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int bit_t(input logic [15:0] pre);
    return (pre == 16'd0) ? 8 : 32'(pre) * 8;
  endfunction

  function automatic logic [7:0] last_rx();
    return rx_log[(rx_n - 1) % 64];
  endfunction

  // Sends one byte and checks txd over every clock of the frame. Called at a negedge.
  task automatic tx_frame(input logic [15:0] pre, input logic [7:0] b, input string tag);
    int T;
    int errs [10];
    int bsy;
    logic [9:0] fr;
    T   = bit_t(pre);
    fr  = {1'b1, b, 1'b0};
    bsy = 0;
    for (int k = 0; k < 10; k++) errs[k] = 0;
    prescale = pre;
    check({tag, " ready idle"}, 32'(tx_ready), 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    prescale = pre + 16'd3;   // must not affect a frame already started
    for (int i = 0; i < 10 * T; i++) begin
      if (txd !== fr[i / T]) errs[i / T]++;
      if (tx_busy !== 1'b1 || tx_ready !== 1'b0) bsy++;
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++) check($sformatf("%s bit%0d bad clocks", tag, k), 32'(errs[k]), 32'd0);
    check({tag, " busy/ready bad clocks"}, 32'(bsy), 32'd0);
    check({tag, " busy after"}, 32'(tx_busy), 32'd0);
    check({tag, " ready after"}, 32'(tx_ready), 32'd1);
    check({tag, " txd after"}, 32'(txd), 32'd1);
  endtask

  // Drives one frame on rxd; must be entered at a negedge.
  task automatic rx_drive(input logic [15:0] pre, input logic [7:0] b, input logic stp);
    int T;
    logic [9:0] fr;
    T  = bit_t(pre);
    fr = {stp, b, 1'b0};
    prescale = pre;
    for (int k = 0; k < 10; k++) begin
      rxd_drv = fr[k];
      repeat (T) @(negedge clk);
    end
    rxd_drv = 1'b1;
  endtask

  typedef struct {
    logic [15:0] pre;
    logic [7:0]  data;
  } tx_vec_t;

  typedef struct {
    logic [15:0] pre;
    logic [7:0]  data;
    logic        stp;
    int          exp_fe;
    int          exp_bytes;
  } rx_vec_t;

  tx_vec_t tx_tab [5];
  rx_vec_t rx_tab [5];

  initial begin
    int s_v, s_o, s_f, s_l, s_n, T, H, t0;
    int hs [3];
    logic [7:0] lb [3];

    tx_tab[0] = '{16'd27, 8'h55};
    tx_tab[1] = '{16'd1,  8'hA5};
    tx_tab[2] = '{16'd0,  8'h3C};
    tx_tab[3] = '{16'd3,  8'h80};
    tx_tab[4] = '{16'd2,  8'hFF};

    rx_tab[0] = '{16'd27, 8'h3C, 1'b1, 0, 1};
    rx_tab[1] = '{16'd4,  8'hA5, 1'b1, 0, 1};
    rx_tab[2] = '{16'd0,  8'h5A, 1'b1, 0, 1};
    rx_tab[3] = '{16'd27, 8'h7E, 1'b0, 1, 0};
    rx_tab[4] = '{16'd2,  8'h00, 1'b1, 0, 1};

    // ---- reset state ----
    @(negedge clk);
    check("rst txd", 32'(txd), 32'd1);
    check("rst tready", 32'(tx_ready), 32'd0);
    check("rst tx_busy", 32'(tx_busy), 32'd0);
    check("rst rx_valid", 32'(rx_valid), 32'd0);
    check("rst rx_data", 32'(rx_data), 32'd0);
    check("rst rx_busy", 32'(rx_busy), 32'd0);
    check("rst errors", 32'({ovr, fe}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst tready", 32'(tx_ready), 32'd1);

    // ---- reset in the middle of a TX frame ----
    prescale = 16'd27;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (300) @(negedge clk);
    check("midtx busy before rst", 32'(tx_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midtx rst txd", 32'(txd), 32'd1);
    check("midtx rst tready", 32'(tx_ready), 32'd0);
    check("midtx rst busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midtx release tready", 32'(tx_ready), 32'd1);
    check("midtx release busy", 32'(tx_busy), 32'd0);

    // ---- TX table ----
    foreach (tx_tab[v]) tx_frame(tx_tab[v].pre, tx_tab[v].data, $sformatf("tx%0d", v));

    // ---- RX table ----
    rx_ready = 1'b1;
    foreach (rx_tab[v]) begin
      s_v = vcyc; s_o = ovr_n; s_f = fe_n; s_l = long_n; s_n = rx_n;
      rx_drive(rx_tab[v].pre, rx_tab[v].data, rx_tab[v].stp);
      repeat (2 * bit_t(rx_tab[v].pre)) @(negedge clk);
      check($sformatf("rx%0d frame_err", v), 32'(fe_n - s_f), 32'(rx_tab[v].exp_fe));
      check($sformatf("rx%0d overrun", v), 32'(ovr_n - s_o), 32'd0);
      check($sformatf("rx%0d valid clocks", v), 32'(vcyc - s_v), 32'(rx_tab[v].exp_bytes));
      check($sformatf("rx%0d bytes", v), 32'(rx_n - s_n), 32'(rx_tab[v].exp_bytes));
      check($sformatf("rx%0d pulse width", v), 32'(long_n - s_l), 32'd0);
      check($sformatf("rx%0d busy after", v), 32'(rx_busy), 32'd0);
      if (rx_tab[v].exp_bytes != 0) check($sformatf("rx%0d data", v), 32'(last_rx()), 32'(rx_tab[v].data));
    end

    // ---- false start ----
    prescale = 16'd27;
    s_v = vcyc; s_f = fe_n;
    rxd_drv = 1'b0;
    repeat (20) @(negedge clk);
    check("false start busy", 32'(rx_busy), 32'd1);
    rxd_drv = 1'b1;
    repeat (300) @(negedge clk);
    check("false start idle", 32'(rx_busy), 32'd0);
    check("false start no err", 32'(fe_n - s_f), 32'd0);
    check("false start no byte", 32'(vcyc - s_v), 32'd0);

    // ---- overrun ----
    T = bit_t(16'd27);
    rx_ready = 1'b0;
    s_o = ovr_n; s_l = long_n;
    rx_drive(16'd27, 8'h11, 1'b1);
    repeat (T) @(negedge clk);
    rx_drive(16'd27, 8'h22, 1'b1);
    repeat (T) @(negedge clk);
    check("overrun count", 32'(ovr_n - s_o), 32'd1);
    check("overrun pulse width", 32'(long_n - s_l), 32'd0);
    check("overrun data", 32'(rx_data), 32'h22);
    check("overrun valid", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    check("overrun drained", 32'(rx_valid), 32'd0);
    check("overrun drained byte", 32'(last_rx()), 32'h22);

    // ---- accept and deliver on the same edge ----
    rx_ready = 1'b0;
    rx_drive(16'd27, 8'h33, 1'b1);
    repeat (T) @(negedge clk);
    check("collide pending", 32'(rx_valid), 32'd1);
    s_o = ovr_n;
    H  = 4 * 27;
    t0 = cyc + 1;
    fork
      rx_drive(16'd27, 8'h44, 1'b1);
      begin
        // Delivery edge: 2 sync clocks + detect + half bit + 9 bits.
        repeat (t0 + 1 + H + 9 * T - cyc) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        check("collide valid", 32'(rx_valid), 32'd1);
        check("collide data", 32'(rx_data), 32'h44);
        rx_ready = 1'b0;
      end
    join
    check("collide no overrun", 32'(ovr_n - s_o), 32'd0);
    check("collide old byte taken", 32'(last_rx()), 32'h33);
    rx_ready = 1'b1;
    @(negedge clk);

    // ---- reset in the middle of an RX frame ----
    s_v = vcyc; s_f = fe_n;
    fork
      rx_drive(16'd27, 8'hFF, 1'b1);
      begin
        repeat (3 * T) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrx rst busy", 32'(rx_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (T) @(negedge clk);
    check("midrx no byte", 32'(vcyc - s_v), 32'd0);
    check("midrx no err", 32'(fe_n - s_f), 32'd0);

    // ---- loopback stream ----
    loopback = 1'b1;
    prescale = 16'd8;
    T = bit_t(16'd8);
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h81;
    s_n = rx_n; s_o = ovr_n; s_f = fe_n;
    for (int i = 0; i < 3; i++) begin
      tx_data  = lb[i];
      tx_valid = 1'b1;
      for (int w = 0; w < 20 * T && !tx_ready; w++) @(negedge clk);
      check($sformatf("lb ready %0d", i), 32'(tx_ready), 32'd1);
      hs[i] = cyc + 1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    repeat (12 * T) @(negedge clk);
    check("lb gap 0-1", 32'(hs[1] - hs[0]), 32'(10 * T + 1));
    check("lb gap 1-2", 32'(hs[2] - hs[1]), 32'(10 * T + 1));
    check("lb count", 32'(rx_n - s_n), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("lb byte %0d", i), 32'(rx_log[(s_n + i) % 64]), 32'(lb[i]));
    check("lb errors", 32'((ovr_n - s_o) + (fe_n - s_f)), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit.
  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

endmodule
